// File: rtl/layer_mem_arbiter.sv
// Two-requester arbiter for the shared layer-memory port.
// Round-robin with burst lock, registered memory command, 2-cycle read return.
module layer_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 20,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [2:0]    sel0,
    input  logic [2:0]    sel1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          cwr,
    output logic          crd,
    output logic [2:0]    csel,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_e;

    localparam logic [3:0] CNT_MAX = 4'(LOCK_MAX);

    state_e        state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [3:0]    lock_cnt_q, lock_cnt_d;
    logic          cwr_q, cwr_d;
    logic          crd_q, crd_d;
    logic [2:0]    csel_q, csel_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic          p1_vld_q, p1_vld_d;
    logic          p1_id_q, p1_id_d;
    logic          p1_nul_q, p1_nul_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          g0, g1, forced;
    logic          acc0, acc1, beat;
    logic          b_we;
    logic [2:0]    b_sel;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [3:0]    cnt_inc;

    // Grant decision; forced hands the port to a starved requester.
    always_comb begin
        g0     = 1'b0;
        g1     = 1'b0;
        forced = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    g0 = rr_last_q;
                    g1 = !rr_last_q;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
            LOCK0: begin
                if (lock_cnt_q == CNT_MAX && req1) begin
                    g1     = 1'b1;
                    forced = 1'b1;
                end else begin
                    g0 = req0;
                end
            end
            LOCK1: begin
                if (lock_cnt_q == CNT_MAX && req0) begin
                    g0     = 1'b1;
                    forced = 1'b1;
                end else begin
                    g1 = req1;
                end
            end
            default: ;
        endcase
    end

    assign gnt0 = g0 && !reset;
    assign gnt1 = g1 && !reset;
    assign acc0 = req0 && gnt0;
    assign acc1 = req1 && gnt1;
    assign beat = acc0 || acc1;

    assign b_we    = acc1 ? we1    : we0;
    assign b_sel   = acc1 ? sel1   : sel0;
    assign b_addr  = acc1 ? addr1  : addr0;
    assign b_wdata = acc1 ? wdata1 : wdata0;
    assign cnt_inc = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc0) begin
                    rr_last_d = 1'b0;
                    if (lock0) begin
                        state_d    = LOCK0;
                        lock_cnt_d = 4'd1;
                    end
                end else if (acc1) begin
                    rr_last_d = 1'b1;
                    if (lock1) begin
                        state_d    = LOCK1;
                        lock_cnt_d = 4'd1;
                    end
                end
            end
            LOCK0: begin
                if (forced) begin
                    rr_last_d  = 1'b1;
                    state_d    = lock1 ? LOCK1 : IDLE;
                    lock_cnt_d = lock1 ? 4'd1 : 4'd0;
                end else if (acc0 && lock0) begin
                    lock_cnt_d = cnt_inc;
                end else begin
                    if (acc0) rr_last_d = 1'b0;
                    state_d    = IDLE;
                    lock_cnt_d = 4'd0;
                end
            end
            LOCK1: begin
                if (forced) begin
                    rr_last_d  = 1'b0;
                    state_d    = lock0 ? LOCK0 : IDLE;
                    lock_cnt_d = lock0 ? 4'd1 : 4'd0;
                end else if (acc1 && lock1) begin
                    lock_cnt_d = cnt_inc;
                end else begin
                    if (acc1) rr_last_d = 1'b1;
                    state_d    = IDLE;
                    lock_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 4'd0;
            end
        endcase
    end

    // Command stage and read-return pipeline.
    always_comb begin
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        p1_vld_d   = beat && !b_we;
        p1_id_d    = acc1;
        p1_nul_d   = (b_sel == 3'b000);
        if (beat) begin
            if (b_sel == 3'b000) begin
                csel_d = 3'b000;
            end else begin
                csel_d = b_sel;
                if (b_we) begin
                    cwr_d      = 1'b1;
                    caddr_wr_d = b_addr;
                    cdata_wr_d = b_wdata;
                end else begin
                    crd_d      = 1'b1;
                    caddr_rd_d = b_addr;
                end
            end
        end
        rvalid0_d = p1_vld_q && !p1_id_q;
        rvalid1_d = p1_vld_q && p1_id_q;
        rdata_d   = rdata_q;
        if (p1_vld_q) rdata_d = p1_nul_q ? '0 : cdata_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            lock_cnt_q <= 4'd0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= 3'b000;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            p1_vld_q   <= 1'b0;
            p1_id_q    <= 1'b0;
            p1_nul_q   <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            p1_vld_q   <= p1_vld_d;
            p1_id_q    <= p1_id_d;
            p1_nul_q   <= p1_nul_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rdata_q;
    assign owner    = state_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: grant/lock checks inline,
// read returns checked by a scoreboard monitor against a memory model.
module tb_layer_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, lock0, lock1, we0, we1;
    logic [2:0]    sel0, sel1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          cwr, crd;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [DW-1:0] cdata_wr, cdata_rd;
    logic [1:0]    owner;

    layer_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .sel0(sel0), .sel1(sel1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: two layers, combinational read, write at clock edge.
    logic [DW-1:0] mem [0:8191];
    assign cdata_rd = mem[{csel[1], caddr_rd}];
    always @(posedge clk) if (cwr) mem[{csel[1], caddr_wr}] <= cdata_wr;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        sel0 = 0; sel1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic push(input logic id, input logic [DW-1:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic pre1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = 1; we1 = 1; sel1 = 3'b001; addr1 = a; wdata1 = d;
        #1 chk("pre_gnt1", gnt1, 1);
        tick();
        req1 = 0; we1 = 0;
    endtask

    always @(negedge clk) begin
        if (gnt0 && gnt1) chk("gnt_both", 1, 0);
        if (rvalid0 || rvalid1) begin
            if (q.size() == 0) begin
                chk("spurious_rvalid", {rvalid1, rvalid0}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rvalid_id", {rvalid1, rvalid0}, e.id ? 2 : 1);
                chk("rdata", rdata, e.data);
            end
        end
    end

    initial begin
        idle_in();
        reset = 1;
        tick();
        req0 = 1; req1 = 1;
        #1;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_strobes", {cwr, crd, rvalid0, rvalid1}, 0);
        chk("rst_csel_owner", {csel, owner}, 0);
        chk("rst_addr", {caddr_wr, caddr_rd}, 0);
        chk("rst_data", {cdata_wr, rdata}, 0);
        tick();
        idle_in();
        reset = 0;
        tick();

        pre1(12'h005, 20'h0ABCD);
        for (int k = 0; k < 4; k++) pre1(12'h040 + 12'(k), 20'h11111 * 20'(k + 1));

        // Round-robin writes, both always requesting.
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        sel0 = 3'b001; addr0 = 12'h020; wdata0 = 20'h0AAAA;
        sel1 = 3'b011; addr1 = 12'h030; wdata1 = 20'h0BBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_gnt0", gnt0, (k % 2 == 0));
            chk("rr_gnt1", gnt1, (k % 2 == 1));
            tick();
            chk("rr_csel", csel, (k % 2 == 0) ? 3'b001 : 3'b011);
            chk("rr_caddr_wr", caddr_wr, (k % 2 == 0) ? 12'h020 : 12'h030);
        end
        idle_in();
        tick();

        // Single read by requester 0.
        req0 = 1; sel0 = 3'b001; addr0 = 12'h005;
        #1 chk("rd_gnt", {gnt1, gnt0}, 2'b01);
        push(0, 20'h0ABCD);
        tick();
        idle_in();
        chk("rd_cmd", {cwr, crd}, 2'b01);
        chk("rd_caddr", caddr_rd, 12'h005);
        tick();
        tick();

        // Locked burst by requester 1 with requester 0 waiting.
        req0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h050; wdata0 = 20'h0CCCC;
        req1 = 1; lock1 = 1; we1 = 0; sel1 = 3'b001;
        for (int k = 0; k < 4; k++) begin
            addr1 = 12'h040 + 12'(k);
            #1 chk("burst_gnt", {gnt1, gnt0}, 2'b10);
            if (k > 0) chk("burst_owner", owner, 2'b10);
            push(1, 20'h11111 * 20'(k + 1));
            tick();
        end
        lock1 = 0; we1 = 1; sel1 = 3'b011; addr1 = 12'h060; wdata1 = 20'h0DDDD;
        #1 chk("burst_wr_gnt", {gnt1, gnt0}, 2'b10);
        chk("burst_wr_owner", owner, 2'b10);
        tick();
        chk("burst_wr_cmd", {cwr, crd, csel}, {2'b10, 3'b011});
        chk("burst_wr_addr", caddr_wr, 12'h060);
        req1 = 0;
        #1 chk("after_burst_gnt0", {gnt1, gnt0}, 2'b01);
        chk("after_burst_owner", owner, 2'b00);
        tick();
        idle_in();
        chk("after_burst_addr", caddr_wr, 12'h050);

        // Lock starvation limit, then saturation with no contender.
        req0 = 1; lock0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h070;
        wdata0 = 20'h01234;
        #1 chk("lk_first", gnt0, 1);
        tick();
        req1 = 1; we1 = 1; sel1 = 3'b001; addr1 = 12'h071; wdata1 = 20'h05678;
        for (int k = 2; k <= 8; k++) begin
            #1 chk("lk_hold", {gnt1, gnt0}, 2'b01);
            tick();
        end
        #1 chk("lk_forced", {gnt1, gnt0}, 2'b10);
        tick();
        chk("lk_forced_addr", caddr_wr, 12'h071);
        #1 chk("lk_rr_after", {gnt1, gnt0}, 2'b01);
        tick();
        req1 = 0;
        for (int k = 0; k < 12; k++) begin
            #1 chk("lk_sat_hold", {gnt1, gnt0}, 2'b01);
            tick();
        end
        req1 = 1;
        #1 chk("lk_sat_forced", {gnt1, gnt0}, 2'b10);
        tick();
        idle_in();
        tick();

        // Write then read same address; then a null-select read.
        req0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h010; wdata0 = 20'h12345;
        tick();
        we0 = 0;
        #1 chk("raw_gnt", gnt0, 1);
        push(0, 20'h12345);
        tick();
        chk("raw_crd", crd, 1);
        sel0 = 3'b000;
        push(0, 20'h00000);
        tick();
        chk("null_cmd", {cwr, crd, csel}, 0);
        idle_in();
        tick();
        tick();
        tick();

        // Reset while a read is in flight.
        req0 = 1; sel0 = 3'b001; addr0 = 12'h005;
        #1 chk("inflight_gnt", gnt0, 1);
        tick();
        reset = 1;
        #1;
        chk("midrst_gnt", {gnt1, gnt0}, 0);
        chk("midrst_strobes", {cwr, crd, rvalid0, rvalid1}, 0);
        chk("midrst_csel_owner", {csel, owner}, 0);
        chk("midrst_addr", {caddr_wr, caddr_rd}, 0);
        chk("midrst_data", {cdata_wr, rdata}, 0);
        tick();
        tick();
        reset = 0;
        idle_in();
        tick();
        tick();
        tick();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; sel0 = 3'b001; sel1 = 3'b001;
        #1 chk("post_rst_rr", {gnt1, gnt0}, 2'b01);
        tick();
        idle_in();
        tick();
        tick();

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
